// File: rtl/reg_mailbox_responder.sv
// Register-bus mailbox: a hardware producer pushes 32-bit words into a FIFO that software pops via DATA reads.
// Optional OVF drop counter at 0x14 is built when MAILBOX_OVERFLOW_CNT_EN is defined.
package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module reg_mailbox_responder
  import reg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  reg_req_t    reg_req_i,
  output reg_rsp_t    reg_rsp_o,
  input  logic        push_valid_i,
  input  logic [31:0] push_data_i,
  output logic        push_ready_o,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [CW-1:0]    count, count_d, thresh;
  logic             irq_en, pending;
  logic             full, empty, push_acc, cap;
  logic             pop_dec, thresh_dec, ctrl_dec, w1c_dec;
  logic             do_pop, do_flush, do_w1c, pending_set;
  logic [31:0]      rdata_d, thresh_new, ctrl_new;
  logic             error_d;
  logic [4:0]       offs;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign push_ready_o = ~full;
  assign push_acc     = push_valid_i & ~full;
  assign irq_o        = pending & irq_en;
  assign cap          = (state == IDLE) & reg_req_i.valid;
  assign offs         = reg_req_i.addr[4:0];

  assign thresh_new = merge(32'(thresh), reg_req_i.wdata, reg_req_i.wstrb);
  assign ctrl_new   = merge({30'b0, irq_en, 1'b0}, reg_req_i.wdata, reg_req_i.wstrb);

`ifdef MAILBOX_OVERFLOW_CNT_EN
  logic [15:0] ovf;
  logic        ovf_dec, ovf_evt;
  assign ovf_evt = push_valid_i & full;
`endif

  always_comb begin
    pop_dec    = 1'b0;
    thresh_dec = 1'b0;
    ctrl_dec   = 1'b0;
    w1c_dec    = 1'b0;
`ifdef MAILBOX_OVERFLOW_CNT_EN
    ovf_dec    = 1'b0;
`endif
    rdata_d    = '0;
    error_d    = 1'b0;
    case (offs)
      5'h00: if (reg_req_i.write || empty) error_d = 1'b1;
             else begin rdata_d = mem[rptr]; pop_dec = 1'b1; end
      5'h04: if (reg_req_i.write) error_d = 1'b1;
             else rdata_d = {{(24-CW){1'b0}}, count, 6'b0, full, empty};
      5'h08: if (reg_req_i.write) thresh_dec = 1'b1;
             else rdata_d = 32'(thresh);
      5'h0C: if (reg_req_i.write) ctrl_dec = 1'b1;
             else rdata_d = {30'b0, irq_en, 1'b0};
      5'h10: if (reg_req_i.write) w1c_dec = reg_req_i.wstrb[0] & reg_req_i.wdata[0];
             else rdata_d = {31'b0, pending};
`ifdef MAILBOX_OVERFLOW_CNT_EN
      5'h14: if (reg_req_i.write) ovf_dec = 1'b1;
             else rdata_d = {16'b0, ovf};
`endif
      default: error_d = 1'b1;
    endcase
  end

  // clear only reaches the FIFO through byte 0, so old bit0 (always 0) merges in as "no clear"
  assign do_pop   = cap & pop_dec;
  assign do_flush = cap & ctrl_dec & ctrl_new[0];
  assign do_w1c   = cap & w1c_dec;

  always_comb begin
    count_d = count;
    if (do_flush) count_d = '0;
    else          count_d = count + CW'(push_acc) - CW'(do_pop);
  end

  assign pending_set = (thresh != '0) && (count < thresh) && (count_d >= thresh);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      thresh  <= '0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      count <= count_d;
      if (do_flush) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (push_acc) wptr <= wptr + 1'b1;
        if (do_pop)   rptr <= rptr + 1'b1;
      end
      if (cap && thresh_dec) thresh <= thresh_new[CW-1:0];
      if (cap && ctrl_dec)   irq_en <= ctrl_new[1];
      pending <= pending_set | (pending & ~do_w1c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      reg_rsp_o <= '0;
    end else begin
      case (state)
        IDLE: if (reg_req_i.valid) begin
          state           <= RESP;
          reg_rsp_o.ready <= 1'b1;
          reg_rsp_o.rdata <= rdata_d;
          reg_rsp_o.error <= error_d;
        end
        RESP: begin
          state     <= IDLE;
          reg_rsp_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAILBOX_OVERFLOW_CNT_EN
  // a drop in the same cycle as the clear survives as 1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          ovf <= '0;
    else if (cap && ovf_dec)              ovf <= 16'(ovf_evt);
    else if (ovf_evt && ovf != 16'hFFFF)  ovf <= ovf + 16'd1;
  end
`endif

  logic unused;
  assign unused = ^{reg_req_i.addr[31:5], thresh_new[31:CW], ctrl_new[31:2], ctrl_new[0]};
endmodule

// File: tb/tb_reg_mailbox_responder.sv
// Randomized bench for reg_mailbox_responder: a queue-based mailbox model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reg_mailbox_responder;
  import reg_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  reg_req_t    req = '0;
  reg_rsp_t    rsp;
  logic        push_valid_i = 1'b0;
  logic [31:0] push_data_i = '0;
  logic        push_ready_o, irq_o;

  reg_mailbox_responder #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .reg_req_i(req), .reg_rsp_o(rsp),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i),
    .push_ready_o(push_ready_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  int unsigned m_thresh = 0;
  bit          m_irq_en = 0, m_pending = 0, m_ready = 0, m_err = 0, acc_last = 0;
  int unsigned m_ovf = 0;
  logic [31:0] m_rdata = '0;

  int unsigned oc, nc, nth;
  bit          acc, ovfe, pop, clr, w1c, wovf, er, nready, setp;
  logic [31:0] rd, tmp;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      m_thresh = 0; m_irq_en = 0; m_pending = 0; m_ovf = 0;
      m_ready = 0; m_err = 0; m_rdata = '0; acc_last = 0;
    end else begin
      oc = mq.size();
      acc = push_valid_i && (oc < DEPTH);
      ovfe = push_valid_i && (oc >= DEPTH);
      pop = 0; clr = 0; w1c = 0; wovf = 0; er = 0; rd = '0; nready = 0;
      nth = m_thresh;
      if (!m_ready && req.valid) begin
        nready = 1;
        case (req.addr[4:0])
          5'h00: if (req.write || oc == 0) er = 1; else begin rd = mq[0]; pop = 1; end
          5'h04: if (req.write) er = 1;
                 else rd = (oc << 8) | ((oc == DEPTH) ? 2 : 0) | ((oc == 0) ? 1 : 0);
          5'h08: if (req.write) begin
                   tmp = m_thresh;
                   for (int b = 0; b < 4; b++) if (req.wstrb[b]) tmp[8*b +: 8] = req.wdata[8*b +: 8];
                   nth = tmp % (1 << CW);
                 end else rd = m_thresh;
          5'h0C: if (req.write) begin
                   if (req.wstrb[0]) begin m_irq_en = req.wdata[1]; clr = req.wdata[0]; end
                 end else rd = m_irq_en ? 2 : 0;
          5'h10: if (req.write) w1c = req.wstrb[0] && req.wdata[0];
                 else rd = m_pending;
`ifdef MAILBOX_OVERFLOW_CNT_EN
          5'h14: if (req.write) wovf = 1; else rd = m_ovf;
`endif
          default: er = 1;
        endcase
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(push_data_i);
      if (clr) mq.delete();
      nc = mq.size();
      setp = (m_thresh != 0) && (oc < m_thresh) && (nc >= m_thresh);
      m_pending = (m_pending && !w1c) || setp;
      m_thresh = nth;
      if (wovf) m_ovf = ovfe ? 1 : 0;
      else if (ovfe && m_ovf < 16'hFFFF) m_ovf++;
      m_ready = nready; m_rdata = rd; m_err = er;
      acc_last = acc;
    end
  end

  always @(negedge clk_i) begin
    chk("rsp_ready", 32'(rsp.ready), 32'(m_ready));
    chk("rsp_error", 32'(rsp.error), 32'(m_err));
    chk("rsp_rdata", rsp.rdata, m_rdata);
    chk("push_ready", 32'(push_ready_o), 32'(mq.size() < DEPTH));
    chk("irq", 32'(irq_o), 32'(m_pending && m_irq_en));
  end

  // ---------------- push driver ----------------
  logic [31:0] pq[$];
  bit rand_push = 0, from_pq = 0;

  always @(negedge clk_i) begin
    #1;
    if (from_pq && acc_last && pq.size() > 0) void'(pq.pop_front());
    if (!rst_ni) begin push_valid_i = 0; from_pq = 0; end
    else if (pq.size() > 0) begin push_valid_i = 1; push_data_i = pq[0]; from_pq = 1; end
    else if (rand_push) begin
      push_valid_i = ($urandom_range(0, 2) == 0); push_data_i = $urandom; from_pq = 0;
    end else begin push_valid_i = 0; from_pq = 0; end
  end

  // ---------------- bus tasks ----------------
  task automatic do_req(input logic [31:0] a, input bit w, input logic [31:0] wd, input logic [3:0] be,
                        input bit pw_en, input logic [31:0] pw,
                        output logic [31:0] rdo, output logic ero, output int lat);
    bit got = 0;
    @(negedge clk_i);
    if (pw_en) pq.push_back(pw);
    req.addr = a; req.write = w; req.wdata = wd; req.wstrb = be; req.valid = 1'b1;
    rdo = '0; ero = 1'b1; lat = -1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_i);
      if (rsp.ready) begin rdo = rsp.rdata; ero = rsp.error; lat = i; got = 1; end
    end
    tests++;
    if (!got) begin fails++; $display("FAIL bus_timeout: no ready for addr %h", a); end
    req.valid = 1'b0;
  endtask

  logic [31:0] rdv;
  logic        erv;
  int          lat;

  task automatic rd_reg(input logic [31:0] a);
    do_req(a, 1'b0, '0, 4'hF, 1'b0, '0, rdv, erv, lat);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    do_req(a, 1'b1, d, be, 1'b0, '0, rdv, erv, lat);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && pq.size() > 0; i++) @(negedge clk_i);
    tests++;
    if (pq.size() > 0) begin fails++; $display("FAIL push_drain: %0d words left", pq.size()); end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  logic [31:0] a, wd;
  logic [3:0]  be;
  bit          w;
  int          k;

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // reset state
    rd_reg(32'h04);
    chk("reset_status", rdv, 32'h0000_0001);
    chk("reset_status_err", 32'(erv), 0);
    chk("reset_latency", 32'(lat), 0);
    chk("reset_push_ready", 32'(push_ready_o), 1);
    chk("reset_irq", 32'(irq_o), 0);

    // fill to full and drain in order
    for (int i = 0; i < 8; i++) pq.push_back(32'hA0 + i);
    drain();
    rd_reg(32'h04);
    chk("full_status", rdv, 32'h0000_0802);
    chk("full_push_ready", 32'(push_ready_o), 0);
    for (int i = 0; i < 8; i++) begin
      rd_reg(32'h00);
      chk("data_order", rdv, 32'hA0 + i);
      chk("data_err", 32'(erv), 0);
    end
    rd_reg(32'h00);
    chk("empty_pop_err", 32'(erv), 1);
    chk("empty_pop_rdata", rdv, 0);

    // threshold interrupt
    wr_reg(32'h08, 32'h3, 4'hF);
    wr_reg(32'h0C, 32'h2, 4'hF);
    for (int i = 0; i < 3; i++) pq.push_back(32'h100 + i);
    drain();
    chk("irq_after_third", 32'(irq_o), 1);
    wr_reg(32'h10, 32'h1, 4'hF);
    chk("irq_w1c", 32'(irq_o), 0);
    pq.push_back(32'h200);
    drain();
    chk("irq_fourth_push", 32'(irq_o), 0);

    // flush, fill, then simultaneous pop and blocked push
    wr_reg(32'h0C, 32'h3, 4'hF);
    rd_reg(32'h04);
    chk("flush_status", rdv, 32'h0000_0001);
    for (int i = 0; i < 8; i++) pq.push_back(32'hB0 + i);
    drain();
    do_req(32'h00, 1'b0, '0, 4'hF, 1'b1, 32'hC0, rdv, erv, lat);
    chk("popfull_data", rdv, 32'hB0);
    drain();
    rd_reg(32'h04);
    chk("popfull_status", rdv, 32'h0000_0802);
    rd_reg(32'h00);
    chk("popfull_head", rdv, 32'hB1);
    rd_reg(32'h14);
`ifdef MAILBOX_OVERFLOW_CNT_EN
    chk("ovf_one", rdv, 1);
`else
    chk("ovf_unmapped", 32'(erv), 1);
`endif

    // erroring requests with no side effect
    wr_reg(32'h00, 32'hDEAD, 4'hF);
    chk("data_write_err", 32'(erv), 1);
    rd_reg(32'h04);
    chk("data_write_cnt", rdv, 32'h0000_0700);
    rd_reg(32'h18);
    chk("unmapped_err", 32'(erv), 1);
    wr_reg(32'h0C, 32'h1, 4'h0);
    rd_reg(32'h0C);
    chk("ctrl_nostrb", rdv, 32'h2);
    rd_reg(32'h04);
    chk("ctrl_nostrb_cnt", rdv, 32'h0000_0700);

    // reset during RESP with 5 entries
    wr_reg(32'h0C, 32'h1, 4'hF);
    for (int i = 0; i < 5; i++) pq.push_back(32'hE0 + i);
    drain();
    @(negedge clk_i);
    req.addr = 32'h04; req.write = 1'b0; req.wstrb = 4'hF; req.valid = 1'b1;
    @(posedge clk_i);
    #2;
    chk("rst_in_resp", 32'(rsp.ready), 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_abort_ready", 32'(rsp.ready), 0);
    req.valid = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd_reg(32'h04);
    chk("rst_status", rdv, 32'h0000_0001);

    // randomized traffic, checked cycle by cycle against the model
    rand_push = 1;
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: a = 32'h00;
        3: a = 32'h04;
        4: a = 32'h08;
        5: a = 32'h0C;
        6: a = 32'h10;
        7: a = 32'h14;
        8: a = 32'h18;
        default: a = $urandom_range(0, 31);
      endcase
      a = a | ($urandom & 32'hFFFF_FFE0);
      w = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (a[4:0] == 5'h0C && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      if (a[4:0] == 5'h08) wd = $urandom_range(0, 12);
      be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      do_req(a, w, wd, be, 1'b0, '0, rdv, erv, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    rand_push = 0;
    repeat (3) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
